ivector_initiator: RTL and testbench

Request-side driver for the IVector say/heard protocol. Accepts a start command, issues a burst of `say` requests with sequenced payloads into an IVector-style responder, and consumes the returning `heard` indications in order. It limits how many requests are in flight, counts what it sent and received, and checks each response against the expected payload. It sits upstream of the responder as a traffic source and self-checker for bring-up and regression.

---
 rtl/ivector_pkg.sv | 19 +
 rtl/ivector_payload_gen.sv | 22 ++
 rtl/ivector_initiator.sv | 153 +++++++++++++++
 tb/tb_ivector_initiator.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ivector_pkg.sv
// ivector_pkg: shared types for the IVector say/heard initiator.
// Holds the FSM state encoding, the default payload width and the {meth, v} bundle.
package ivector_pkg;

    localparam int IVECTOR_DATA_WIDTH = 192;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [IVECTOR_DATA_WIDTH-1:0] meth;
        logic [IVECTOR_DATA_WIDTH-1:0] v;
    } payload_t;

endpackage

// File: rtl/ivector_payload_gen.sv
// ivector_payload_gen: sequenced payload, {meth, v} = base + idx (mod 2^DATA_WIDTH).
// Ports: base_meth/base_v burst base, idx zero-extended sequence index, meth/v result.
module ivector_payload_gen
    import ivector_pkg::*;
#(
    parameter int DATA_WIDTH  = IVECTOR_DATA_WIDTH,
    parameter int COUNT_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]  base_meth,
    input  logic [DATA_WIDTH-1:0]  base_v,
    input  logic [COUNT_WIDTH-1:0] idx,
    output logic [DATA_WIDTH-1:0]  meth,
    output logic [DATA_WIDTH-1:0]  v
);

    logic [DATA_WIDTH-1:0] idx_ext;

    assign idx_ext = DATA_WIDTH'(idx);
    assign meth    = base_meth + idx_ext;
    assign v       = base_v + idx_ext;

endmodule

// File: rtl/ivector_initiator.sv
// ivector_initiator: issues a burst of sequenced say requests and checks the heard replies.
// Ports: CLK/nRST; start__ENA/RDY + start_count/meth/v command; say__ENA/RDY + say_meth/v
// request; heard__ENA/RDY + heard_meth/v reply; done pulse; sent/recv/error counters.
// Build option: IVECTOR_INITIATOR_CHECK_EN enables the payload comparator and error_count.
module ivector_initiator
    import ivector_pkg::*;
#(
    parameter int DATA_WIDTH      = IVECTOR_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 2,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   start__ENA,
    input  logic [COUNT_WIDTH-1:0] start_count,
    input  logic [DATA_WIDTH-1:0]  start_meth,
    input  logic [DATA_WIDTH-1:0]  start_v,
    output logic                   start__RDY,
    output logic                   say__ENA,
    output logic [DATA_WIDTH-1:0]  say_meth,
    output logic [DATA_WIDTH-1:0]  say_v,
    input  logic                   say__RDY,
    input  logic                   heard__ENA,
    input  logic [DATA_WIDTH-1:0]  heard_meth,
    input  logic [DATA_WIDTH-1:0]  heard_v,
    output logic                   heard__RDY,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] sent_count,
    output logic [COUNT_WIDTH-1:0] recv_count,
    output logic [COUNT_WIDTH-1:0] error_count
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    state_t                 state;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0]  base_meth_q;
    logic [DATA_WIDTH-1:0]  base_v_q;
    logic [OUT_W-1:0]       outstanding;

    logic start_fire;
    logic heard_fire;
    logic last_say;
    logic last_heard;

    // start__RDY is held low while reset is asserted so every output reads 0.
    assign start__RDY = nRST && (state == IDLE);
    assign say__ENA   = (state == RUN) && say__RDY && (outstanding < OUT_MAX);
    assign heard__RDY = ((state == RUN) || (state == DRAIN)) && (outstanding != '0);
    assign done       = (state == DONE);

    assign start_fire = start__ENA && start__RDY;
    assign heard_fire = heard__ENA && heard__RDY;
    assign last_say   = say__ENA && ((sent_count + CNT_ONE) == count_q);
    assign last_heard = heard_fire && ((recv_count + CNT_ONE) == count_q);

    ivector_payload_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_say_gen (
        .base_meth(base_meth_q),
        .base_v   (base_v_q),
        .idx      (sent_count),
        .meth     (say_meth),
        .v        (say_v)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            count_q     <= '0;
            base_meth_q <= '0;
            base_v_q    <= '0;
            sent_count  <= '0;
            recv_count  <= '0;
            outstanding <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_fire) begin
                        count_q     <= start_count;
                        base_meth_q <= start_meth;
                        base_v_q    <= start_v;
                        sent_count  <= '0;
                        recv_count  <= '0;
                        outstanding <= '0;
                        state       <= (start_count != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (last_say)
                        state <= last_heard ? DONE : DRAIN;
                end
                DRAIN: begin
                    if (last_heard)
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (say__ENA)
                sent_count <= sent_count + CNT_ONE;
            if (heard_fire)
                recv_count <= recv_count + CNT_ONE;

            // Simultaneous say and heard leave the in-flight count unchanged.
            unique case (1'b1)
                say__ENA && !heard_fire: outstanding <= outstanding + OUT_ONE;
                heard_fire && !say__ENA: outstanding <= outstanding - OUT_ONE;
                default: ;
            endcase
        end
    end

`ifdef IVECTOR_INITIATOR_CHECK_EN
    logic [DATA_WIDTH-1:0] exp_meth;
    logic [DATA_WIDTH-1:0] exp_v;
    logic                  mismatch;

    // Replies return in request order, so recv_count indexes the expected payload.
    ivector_payload_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_exp_gen (
        .base_meth(base_meth_q),
        .base_v   (base_v_q),
        .idx      (recv_count),
        .meth     (exp_meth),
        .v        (exp_v)
    );

    assign mismatch = (heard_meth != exp_meth) || (heard_v != exp_v);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            error_count <= '0;
        else if (start_fire)
            error_count <= '0;
        else if (heard_fire && mismatch && (error_count != '1))
            error_count <= error_count + CNT_ONE;
    end
`else
    logic unused_heard;

    assign error_count  = '0;
    assign unused_heard = ^{heard_meth, heard_v};
`endif

endmodule

// File: tb/tb_ivector_initiator.sv
// tb_ivector_initiator: randomized responder plus scoreboard for ivector_initiator.
// Expected says and burst results are queued at start; a monitor pops and compares.
module tb_ivector_initiator;
    import ivector_pkg::*;

    localparam int DW = 192;
    localparam int CW = 16;
    localparam int MO = 2;

`ifdef IVECTOR_INITIATOR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          CLK;
    logic          nRST;
    logic          start__ENA;
    logic [CW-1:0] start_count;
    logic [DW-1:0] start_meth;
    logic [DW-1:0] start_v;
    logic          start__RDY;
    logic          say__ENA;
    logic [DW-1:0] say_meth;
    logic [DW-1:0] say_v;
    logic          say__RDY;
    logic          heard__ENA;
    logic [DW-1:0] heard_meth;
    logic [DW-1:0] heard_v;
    logic          heard__RDY;
    logic          done;
    logic [CW-1:0] sent_count;
    logic [CW-1:0] recv_count;
    logic [CW-1:0] error_count;

    ivector_initiator #(
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(MO),
        .COUNT_WIDTH    (CW)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .start__ENA (start__ENA),
        .start_count(start_count),
        .start_meth (start_meth),
        .start_v    (start_v),
        .start__RDY (start__RDY),
        .say__ENA   (say__ENA),
        .say_meth   (say_meth),
        .say_v      (say_v),
        .say__RDY   (say__RDY),
        .heard__ENA (heard__ENA),
        .heard_meth (heard_meth),
        .heard_v    (heard_v),
        .heard__RDY (heard__RDY),
        .done       (done),
        .sent_count (sent_count),
        .recv_count (recv_count),
        .error_count(error_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int sent;
        int recv;
        int err;
    } res_t;

    int checks = 0;
    int errors = 0;

    payload_t exp_say_q[$];
    payload_t resp_q[$];
    bit       corrupt_q[$];
    res_t     exp_res_q[$];

    bit in_reset  = 1'b1;
    bit force_low = 1'b0;
    int rdy_pct   = 100;
    int hrd_pct   = 100;

    int mcyc          = 0;
    int done_due      = -1;
    int m_sent        = 0;
    int m_recv        = 0;
    int m_out         = 0;
    int cur_count     = 0;
    int n_done        = 0;
    int start_cyc     = 0;
    int first_say_cyc = -1;
    int done_cyc      = 0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_dw();
        return {$urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom()};
    endfunction

    // Responder: random backpressure, echoes each accepted say as a heard.
    initial begin
        say__RDY   = 1'b0;
        heard__ENA = 1'b0;
        heard_meth = '0;
        heard_v    = '0;
        forever begin
            @(negedge CLK);
            if (in_reset) begin
                say__RDY   = 1'b0;
                heard__ENA = 1'b0;
            end else begin
                say__RDY = !force_low && ($urandom_range(99) < rdy_pct);
                if (heard__RDY && resp_q.size() > 0 &&
                    $urandom_range(99) < hrd_pct) begin
                    heard__ENA = 1'b1;
                    heard_meth = resp_q[0].meth;
                    heard_v    = resp_q[0].v + DW'(corrupt_q[0]);
                end else begin
                    heard__ENA = 1'b0;
                end
                #1;
                if (say__ENA)
                    resp_q.push_back('{meth: say_meth, v: say_v});
                if (heard__ENA) begin
                    void'(resp_q.pop_front());
                    void'(corrupt_q.pop_front());
                end
            end
        end
    end

    // Monitor: compares every say and every burst completion with the scoreboard.
    initial begin
        payload_t p;
        res_t     r;
        forever begin
            @(negedge CLK);
            #2;
            if (in_reset) begin
                m_sent   = 0;
                m_recv   = 0;
                m_out    = 0;
                done_due = -1;
            end else begin
                mcyc++;
                if (start__ENA && start__RDY) begin
                    cur_count     = int'(start_count);
                    m_sent        = 0;
                    m_recv        = 0;
                    m_out         = 0;
                    start_cyc     = mcyc;
                    first_say_cyc = -1;
                    if (start_count == '0)
                        done_due = mcyc + 1;
                end
                if (!say__RDY)
                    chk("say_gated", say__ENA, 0);
                if (say__ENA) begin
                    if (exp_say_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL say_extra: got say %0h expected none", say_meth);
                    end else begin
                        p = exp_say_q.pop_front();
                        chk("say_meth", say_meth, p.meth);
                        chk("say_v", say_v, p.v);
                    end
                    chk("outstanding_cap", (m_out < MO), 1);
                    if (first_say_cyc < 0)
                        first_say_cyc = mcyc;
                    m_sent++;
                    m_out++;
                end
                if (heard__ENA) begin
                    m_recv++;
                    m_out--;
                    if (m_recv == cur_count)
                        done_due = mcyc + 1;
                end
                if (done || mcyc == done_due) begin
                    chk("done_timing", {done, (mcyc == done_due)}, 3);
                    if (done) begin
                        n_done++;
                        done_cyc = mcyc;
                        done_due = -1;
                        if (exp_res_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL done_extra: got done expected none");
                        end else begin
                            r = exp_res_q.pop_front();
                            chk("sent_count", sent_count, r.sent);
                            chk("recv_count", recv_count, r.recv);
                            chk("error_count", error_count, r.err);
                        end
                    end
                end
            end
        end
    end

    // corrupt_sel: -1 none, -2 random, otherwise index of the heard to corrupt.
    task automatic start_burst(input int cnt, input logic [DW-1:0] bm,
                               input logic [DW-1:0] bv, input int corrupt_sel);
        int nerr;
        int g;
        bit c;
        nerr = 0;
        g    = 0;
        while (!start__RDY && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (!start__RDY) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: got start__RDY 0 expected 1");
        end
        for (int i = 0; i < cnt; i++) begin
            c = (corrupt_sel == i) ||
                (corrupt_sel == -2 && $urandom_range(4) == 0);
            exp_say_q.push_back('{meth: bm + DW'(i), v: bv + DW'(i)});
            corrupt_q.push_back(c);
            if (c)
                nerr++;
        end
        exp_res_q.push_back('{sent: cnt, recv: cnt, err: CHECK_EN ? nerr : 0});
        start__ENA  = 1'b1;
        start_count = CW'(cnt);
        start_meth  = bm;
        start_v     = bv;
        @(negedge CLK);
        start__ENA  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int g;
        g = 0;
        while (n_done < target && g < 3000) begin
            @(negedge CLK);
            g++;
        end
        if (n_done < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d bursts expected %0d", n_done, target);
        end
        @(negedge CLK);
    endtask

    task automatic wait_sent(input int n);
        int g;
        g = 0;
        while (m_sent < n && g < 500) begin
            @(negedge CLK);
            g++;
        end
        if (m_sent < n) begin
            checks++;
            errors++;
            $display("FAIL sent_timeout: got %0d says expected %0d", m_sent, n);
        end
    endtask

    initial begin
        int nd;
        logic [DW-1:0] wrap;
        nd          = 0;
        start__ENA  = 1'b0;
        start_count = '0;
        start_meth  = '0;
        start_v     = '0;
        nRST        = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_start_rdy", start__RDY, 0);
        chk("rst_say_ena", say__ENA, 0);
        chk("rst_heard_rdy", heard__RDY, 0);
        chk("rst_done", done, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_err", error_count, 0);
        nRST     = 1'b1;
        in_reset = 1'b0;
        @(negedge CLK);
        chk("idle_start_rdy", start__RDY, 1);

        // Always-ready responder: one say per cycle.
        rdy_pct = 100;
        hrd_pct = 100;
        start_burst(4, 'h10, 'h100, -1);
        nd++;
        wait_done(nd);
        chk("first_say_lat", first_say_cyc - start_cyc, 1);
        chk("burst_len", done_cyc - start_cyc, 6);
        chk("done_one_cycle", done, 0);

        // Say backpressure held for five cycles mid-burst.
        start_burst(4, rand_dw(), rand_dw(), -1);
        nd++;
        wait_sent(2);
        force_low = 1'b1;
        repeat (5) @(negedge CLK);
        force_low = 1'b0;
        wait_done(nd);

        // Second reply corrupted in v.
        start_burst(4, rand_dw(), rand_dw(), 1);
        nd++;
        wait_done(nd);

        // Empty burst.
        start_burst(0, rand_dw(), rand_dw(), -1);
        nd++;
        wait_done(nd);
        chk("zero_done_lat", done_cyc - start_cyc, 1);

        // meth wraps past all-ones.
        wrap = '1;
        wrap = wrap - 1;
        start_burst(3, wrap, 'h7, -1);
        nd++;
        wait_done(nd);

        // Asynchronous reset with two says in flight.
        hrd_pct = 0;
        start_burst(6, 'h55, 'h66, -1);
        wait_sent(2);
        @(posedge CLK);
        #2;
        nRST     = 1'b0;
        in_reset = 1'b1;
        #1;
        chk("arst_say_ena", say__ENA, 0);
        chk("arst_say_meth", say_meth, 0);
        chk("arst_say_v", say_v, 0);
        chk("arst_heard_rdy", heard__RDY, 0);
        chk("arst_start_rdy", start__RDY, 0);
        chk("arst_done", done, 0);
        chk("arst_sent", sent_count, 0);
        chk("arst_recv", recv_count, 0);
        chk("arst_err", error_count, 0);
        exp_say_q.delete();
        resp_q.delete();
        corrupt_q.delete();
        exp_res_q.delete();
        repeat (2) @(negedge CLK);
        nRST     = 1'b1;
        in_reset = 1'b0;
        hrd_pct  = 100;
        @(negedge CLK);
        chk("post_rst_start_rdy", start__RDY, 1);
        start_burst(5, rand_dw(), rand_dw(), -1);
        nd++;
        wait_done(nd);

        // Randomized bursts with random backpressure and corruption.
        for (int k = 0; k < 15; k++) begin
            rdy_pct = $urandom_range(100, 30);
            hrd_pct = $urandom_range(100, 30);
            start_burst($urandom_range(10, 0), rand_dw(), rand_dw(), -2);
            nd++;
            wait_done(nd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
